// File: rtl/store_align_pkg.sv
// Shared types and constants for the store alignment path.
package store_align_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_e;

  localparam logic [3:0]  LANE_ALL = 4'b1111;
  localparam int unsigned BYTE_W   = 8;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane steering: byte-enable mask and shifted write data for one beat.
module store_lane_gen
  import store_align_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        beat_sel,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  bmask,
  output logic        split
);

  logic [3:0]  size_mask;
  logic [31:0] data_sized;
  logic [7:0]  mask_wide;
  logic [63:0] data_wide;
  logic [5:0]  shamt;

  // Build the unshifted lane mask and zero lanes above the access size, then
  // shift across a two-word window: low half is beat 0, high half is beat 1.
  always_comb begin
    size_mask  = 4'b0000;
    data_sized = 32'h0;
    unique case (size)
      SZ_B: begin
        size_mask  = 4'b0001;
        data_sized = {24'h0, data[7:0]};
      end
      SZ_H: begin
        size_mask  = 4'b0011;
        data_sized = {16'h0, data[15:0]};
      end
      SZ_W: begin
        size_mask  = LANE_ALL;
        data_sized = data;
      end
      default: begin
        size_mask  = 4'b0000;
        data_sized = 32'h0;
      end
    endcase

    shamt     = 6'(32'(off) * BYTE_W);
    mask_wide = {4'b0000, size_mask} << off;
    data_wide = {32'h0, data_sized} << shamt;

    split = |mask_wide[7:4];
    bmask = beat_sel ? mask_wide[7:4]  : mask_wide[3:0];
    wdata = beat_sel ? data_wide[63:32] : data_wide[31:0];
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: turns MEM-stage stores into word-aligned write beats,
// splitting misaligned halfword/word stores into two beats.
module store_align_unit
  import store_align_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter bit          RESV_ERR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_st_valid,
  output logic              o_st_ready,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [31:0]       i_st_data,
  input  logic [1:0]        i_st_size,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_busy,
  output logic              o_err
);

  state_e      state;
  logic        split_q;
  logic [1:0]  off_q;
  size_e       size_q;
  logic [31:0] data_q;

  logic        last_beat;
  logic        accept;
  logic        use_q;
  size_e       st_size;
  logic [1:0]  lg_off;
  size_e       lg_size;
  logic [31:0] lg_data;
  logic [31:0] lg_wdata;
  logic [3:0]  lg_bmask;
  logic        lg_split;

  // Handshake decode and lane-generator input select (stored request for beat 1).
  always_comb begin
    st_size    = size_e'(i_st_size);
    last_beat  = (state == BEAT1) || ((state == BEAT0) && !split_q);
    o_st_ready = i_reset && ((state == IDLE) || (last_beat && i_mem_ready));
    accept     = i_st_valid && o_st_ready;
    use_q      = (state == BEAT0) && split_q;
    lg_off     = use_q ? off_q  : i_st_addr[1:0];
    lg_size    = use_q ? size_q : st_size;
    lg_data    = use_q ? data_q : i_st_data;
  end

  store_lane_gen u_lane_gen (
    .off      (lg_off),
    .size     (lg_size),
    .beat_sel (use_q),
    .data     (lg_data),
    .wdata    (lg_wdata),
    .bmask    (lg_bmask),
    .split    (lg_split)
  );

  // Beat sequencer with registered memory-side outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= IDLE;
      split_q     <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SZ_B;
      data_q      <= 32'h0;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= 32'h0;
      o_mem_bmask <= 4'b0000;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (accept) begin
        if (st_size == SZ_RSV) begin
          state       <= IDLE;
          o_mem_valid <= 1'b0;
          o_busy      <= 1'b0;
          o_err       <= RESV_ERR;
        end else begin
          state       <= BEAT0;
          split_q     <= lg_split;
          off_q       <= i_st_addr[1:0];
          size_q      <= st_size;
          data_q      <= i_st_data;
          o_mem_valid <= 1'b1;
          o_mem_addr  <= {i_st_addr[ADDR_W-1:2], 2'b00};
          o_mem_wdata <= lg_wdata;
          o_mem_bmask <= lg_bmask;
          o_busy      <= 1'b1;
        end
      end else if (o_mem_valid && i_mem_ready) begin
        if (use_q) begin
          state       <= BEAT1;
          o_mem_addr  <= o_mem_addr + ADDR_W'(4);
          o_mem_wdata <= lg_wdata;
          o_mem_bmask <= lg_bmask;
        end else begin
          state       <= IDLE;
          o_mem_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit with hand-computed beat expectations.
module tb_store_align_unit;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic        busy;
  logic        err;

  int n_tests;
  int n_fail;

  store_align_unit #(.ADDR_W(32), .RESV_ERR(1'b1)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_st_valid  (st_valid),
    .o_st_ready  (st_ready),
    .i_st_addr   (st_addr),
    .i_st_data   (st_data),
    .i_st_size   (st_size),
    .o_mem_valid (mem_valid),
    .i_mem_ready (mem_ready),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_bmask (mem_bmask),
    .o_busy      (busy),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] w,
                            input logic [3:0] m);
    check({tag, ".valid"}, 32'(mem_valid), 32'd1);
    check({tag, ".addr"},  mem_addr, a);
    check({tag, ".wdata"}, mem_wdata, w);
    check({tag, ".bmask"}, 32'(mem_bmask), 32'(m));
  endtask

  // Issue one store with memory always ready and check each beat it produces.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input bit two,
                          input logic [31:0] a0, input logic [31:0] w0, input logic [3:0] m0,
                          input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] m1);
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    st_size  = size;
    check({tag, ".st_ready"}, 32'(st_ready), 32'd1);
    @(negedge clk);
    st_valid = 1'b0;
    check_beat({tag, ".b0"}, a0, w0, m0);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    if (two) begin
      @(negedge clk);
      check_beat({tag, ".b1"}, a1, w1, m1);
    end
    @(negedge clk);
    check({tag, ".done_valid"}, 32'(mem_valid), 32'd0);
    check({tag, ".done_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    st_valid  = 1'b0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    st_size   = 2'b00;
    mem_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(mem_valid), 32'd0);
    check("rst.addr",  mem_addr, 32'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    check("rst.bmask", 32'(mem_bmask), 32'h0);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.err",   32'(err), 32'd0);
    check("rst.st_ready", 32'(st_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst.st_ready", 32'(st_ready), 32'd1);

    // Single-beat cases
    do_store("byte_1002", 32'h0000_1002, 32'h0000_00AB, 2'b00, 1'b0,
             32'h0000_1000, 32'h00AB_0000, 4'b0100, 32'h0, 32'h0, 4'b0);
    do_store("byte_1003", 32'h0000_1003, 32'h1234_56CD, 2'b00, 1'b0,
             32'h0000_1000, 32'hCD00_0000, 4'b1000, 32'h0, 32'h0, 4'b0);
    do_store("half_5002", 32'h0000_5002, 32'hAAAA_1234, 2'b01, 1'b0,
             32'h0000_5000, 32'h1234_0000, 4'b1100, 32'h0, 32'h0, 4'b0);
    do_store("half_8001", 32'h0000_8001, 32'h0000_5678, 2'b01, 1'b0,
             32'h0000_8000, 32'h0056_7800, 4'b0110, 32'h0, 32'h0, 4'b0);
    do_store("word_6000", 32'h0000_6000, 32'hDEAD_BEEF, 2'b10, 1'b0,
             32'h0000_6000, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'b0);

    // Split cases
    do_store("word_2001", 32'h0000_2001, 32'h1122_3344, 2'b10, 1'b1,
             32'h0000_2000, 32'h2233_4400, 4'b1110, 32'h0000_2004, 32'h0000_0011, 4'b0001);
    do_store("word_7003", 32'h0000_7003, 32'h1122_3344, 2'b10, 1'b1,
             32'h0000_7000, 32'h4400_0000, 4'b1000, 32'h0000_7004, 32'h0011_2233, 4'b0111);
    do_store("half_wrap", 32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01, 1'b1,
             32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000, 32'h0000_0000, 32'h0000_00BE, 4'b0001);

    // Stall then back-to-back second word
    @(negedge clk);
    mem_ready = 1'b0;
    st_valid  = 1'b1;
    st_addr   = 32'h0000_3000;
    st_data   = 32'hCAFE_F00D;
    st_size   = 2'b10;
    check("stall.accept_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    st_addr = 32'h0000_3004;
    st_data = 32'h0BAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check_beat("stall.hold", 32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
      check("stall.st_ready", 32'(st_ready), 32'd0);
    end
    mem_ready = 1'b1;
    #1;
    check("stall.release_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    st_valid = 1'b0;
    check_beat("b2b", 32'h0000_3004, 32'h0BAD_BEEF, 4'b1111);
    @(negedge clk);
    check("b2b.done", 32'(mem_valid), 32'd0);

    // Reserved size
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = 32'h0000_9001;
    st_data  = 32'h5555_5555;
    st_size  = 2'b11;
    check("rsv.st_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    st_valid = 1'b0;
    check("rsv.valid", 32'(mem_valid), 32'd0);
    check("rsv.err",   32'(err), 32'd1);
    check("rsv.busy",  32'(busy), 32'd0);
    @(negedge clk);
    check("rsv.err_clr", 32'(err), 32'd0);
    check("rsv.valid2",  32'(mem_valid), 32'd0);

    // Reset during beat 1 of a split word
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = 32'h0000_4003;
    st_data  = 32'h1122_3344;
    st_size  = 2'b10;
    @(negedge clk);
    st_valid = 1'b0;
    check_beat("mrst.b0", 32'h0000_4000, 32'h4400_0000, 4'b1000);
    @(negedge clk);
    check_beat("mrst.b1", 32'h0000_4004, 32'h0011_2233, 4'b0111);
    rst = 1'b0;
    @(negedge clk);
    check("mrst.valid", 32'(mem_valid), 32'd0);
    check("mrst.busy",  32'(busy), 32'd0);
    check("mrst.addr",  mem_addr, 32'h0);
    check("mrst.wdata", mem_wdata, 32'h0);
    check("mrst.bmask", 32'(mem_bmask), 32'h0);
    check("mrst.st_ready", 32'(st_ready), 32'd0);
    rst = 1'b1;
    do_store("post_mrst", 32'h0000_1001, 32'h0000_0077, 2'b00, 1'b0,
             32'h0000_1000, 32'h0000_7700, 4'b0010, 32'h0, 32'h0, 4'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
